rvsteel_spi_sequencer: RTL and testbench

//  CPU-side byte streamer placed upstream of the SPI controller. CPU pushes TX bytes into a FIFO.
//  A master-port FSM writes each byte to the controller's WDATA, polls STATUS until the shift

---
 rtl/rvsteel_spi_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_rvsteel_spi_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rvsteel_spi_sequencer
// Brief    : CPU-side TX/RX byte streamer driving an SPI controller through a
//            master port. Optional IRQ output enabled by SPI_SEQ_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rvsteel_spi_sequencer #(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETTLE_CYCLES = 2   // minimum 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
`ifdef SPI_SEQ_IRQ_EN
  output logic        irq,
`endif
  output logic [4:0]  m_rw_address,
  input  logic [31:0] m_read_data,
  output logic        m_read_request,
  input  logic        m_read_response,
  output logic [7:0]  m_write_data,
  output logic [3:0]  m_write_strobe,
  output logic        m_write_request,
  input  logic        m_write_response
);

  localparam int c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W    = c_PTR_W + 1;
  localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [4:0] c_REG_TXDATA  = 5'h00;
  localparam logic [4:0] c_REG_RXDATA  = 5'h04;
  localparam logic [4:0] c_REG_STATUS  = 5'h08;
  localparam logic [4:0] c_REG_CONTROL = 5'h0C;
  localparam logic [4:0] c_REG_IRQ_EN  = 5'h10;

  localparam logic [4:0] c_CTL_CS     = 5'h08;
  localparam logic [4:0] c_CTL_WDATA  = 5'h10;
  localparam logic [4:0] c_CTL_RDATA  = 5'h14;
  localparam logic [4:0] c_CTL_STATUS = 5'h18;

  localparam logic [31:0] c_DEFAULT_READ = 32'hdeadbeef;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CS_WR, ST_TX_WR, ST_POLL, ST_SETTLE, ST_RX_RD
  } state_t;

  state_t                r_state;
  logic                  r_busy_seen;
  logic [c_SETTLE_W-1:0] r_settle_cnt;

  logic [7:0]         r_tx_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
  logic [c_CNT_W-1:0] r_tx_count;
  logic [7:0]         r_rx_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
  logic [c_CNT_W-1:0] r_rx_count;

  logic       r_enable;
  logic [7:0] r_cs;
  logic       r_cs_pending;
  logic       r_overflow;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_wr_en, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic w_start_cs, w_start_tx, w_busy;
  logic w_unused;

  assign w_tx_full  = (r_tx_count == c_CNT_W'(FIFO_DEPTH));
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == c_CNT_W'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_count == '0);

  assign w_wr_en    = write_request & (write_strobe == 4'hF);
  assign w_tx_push  = w_wr_en & (rw_address == c_REG_TXDATA) & ~w_tx_full;
  assign w_rx_pop   = read_request & (rw_address == c_REG_RXDATA) & ~w_rx_empty;
  assign w_rx_push  = (r_state == ST_RX_RD) & m_read_response;

  // A pending CS update always goes out before the next data byte.
  assign w_start_cs = (r_state == ST_IDLE) & r_cs_pending;
  assign w_start_tx = (r_state == ST_IDLE) & r_enable & ~w_tx_empty & ~w_rx_full & ~r_cs_pending;
  assign w_tx_pop   = w_start_tx;
  assign w_busy     = (r_state != ST_IDLE) | (r_enable & ~w_tx_empty);

  assign m_write_strobe = 4'hF;
  assign w_unused       = ^{write_data[31:16], m_read_data[31:8]};

  // FIFO storage carries no reset; only the pointers and counts are flushed.
  always_ff @(posedge clock) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= write_data[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= m_read_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

`ifdef SPI_SEQ_IRQ_EN
  logic [1:0] r_irq_en;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      read_data      <= c_DEFAULT_READ;
      read_response  <= 1'b0;
      write_response <= 1'b0;
      r_enable       <= 1'b0;
      r_cs           <= 8'h00;
      r_cs_pending   <= 1'b0;
      r_overflow     <= 1'b0;
`ifdef SPI_SEQ_IRQ_EN
      r_irq_en       <= 2'b00;
`endif
    end else begin
      read_response  <= read_request;
      write_response <= write_request;
      read_data      <= c_DEFAULT_READ;
      if (read_request) begin
        case (rw_address)
          c_REG_RXDATA:  read_data <= w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rd_ptr]};
          c_REG_STATUS:  read_data <= {8'h00, 8'(r_rx_count), 8'(r_tx_count), 2'b00, r_overflow,
                                       w_busy, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
          c_REG_CONTROL: read_data <= {16'h0, r_cs, 7'h0, r_enable};
`ifdef SPI_SEQ_IRQ_EN
          c_REG_IRQ_EN:  read_data <= {30'h0, r_irq_en};
`endif
          default:       read_data <= c_DEFAULT_READ;
        endcase
      end
      if (w_start_cs) r_cs_pending <= 1'b0;
      if (w_wr_en) begin
        case (rw_address)
          c_REG_TXDATA:  if (w_tx_full) r_overflow <= 1'b1;
          c_REG_STATUS:  r_overflow <= 1'b0;
          c_REG_CONTROL: begin
            r_enable     <= write_data[0];
            r_cs         <= write_data[15:8];
            r_cs_pending <= 1'b1;
          end
`ifdef SPI_SEQ_IRQ_EN
          c_REG_IRQ_EN:  r_irq_en <= write_data[1:0];
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_SEQ_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset) irq <= 1'b0;
    else       irq <= (r_irq_en[0] & w_tx_empty & (r_state == ST_IDLE)) | (r_irq_en[1] & ~w_rx_empty);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_busy_seen     <= 1'b0;
      r_settle_cnt    <= '0;
      m_rw_address    <= 5'h00;
      m_write_data    <= 8'h00;
      m_read_request  <= 1'b0;
      m_write_request <= 1'b0;
    end else begin
      m_read_request  <= 1'b0;
      m_write_request <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_cs) begin
            r_state         <= ST_CS_WR;
            m_rw_address    <= c_CTL_CS;
            m_write_data    <= r_cs;
            m_write_request <= 1'b1;
          end else if (w_start_tx) begin
            r_state         <= ST_TX_WR;
            m_rw_address    <= c_CTL_WDATA;
            m_write_data    <= r_tx_mem[r_tx_rd_ptr];
            m_write_request <= 1'b1;
          end
        end
        ST_CS_WR: if (m_write_response) r_state <= ST_IDLE;
        ST_TX_WR: begin
          if (m_write_response) begin
            r_state        <= ST_POLL;
            r_busy_seen    <= 1'b0;
            m_rw_address   <= c_CTL_STATUS;
            m_read_request <= 1'b1;
          end
        end
        ST_POLL: begin
          // The shift is done only once busy has been seen high and then low.
          if (m_read_response) begin
            if (m_read_data[0]) r_busy_seen <= 1'b1;
            if (r_busy_seen && !m_read_data[0]) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= c_SETTLE_W'(SETTLE_CYCLES - 1);
            end else begin
              m_read_request <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_state        <= ST_RX_RD;
            m_rw_address   <= c_CTL_RDATA;
            m_read_request <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end
        ST_RX_RD: if (m_read_response) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvsteel_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvsteel_spi_sequencer
// Brief    : Self-checking bench with a loopback SPI controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvsteel_spi_sequencer;

  localparam int c_DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rw_address = '0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic [4:0]  m_rw_address;
  logic [31:0] m_read_data;
  logic        m_read_request;
  logic        m_read_response;
  logic [7:0]  m_write_data;
  logic [3:0]  m_write_strobe;
  logic        m_write_request;
  logic        m_write_response;
`ifdef SPI_SEQ_IRQ_EN
  logic        irq;
`endif

  rvsteel_spi_sequencer #(.FIFO_DEPTH(c_DEPTH), .SETTLE_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .rw_address(rw_address), .read_data(read_data),
    .read_request(read_request), .read_response(read_response), .write_data(write_data),
    .write_strobe(write_strobe), .write_request(write_request), .write_response(write_response),
`ifdef SPI_SEQ_IRQ_EN
    .irq(irq),
`endif
    .m_rw_address(m_rw_address), .m_read_data(m_read_data), .m_read_request(m_read_request),
    .m_read_response(m_read_response), .m_write_data(m_write_data), .m_write_strobe(m_write_strobe),
    .m_write_request(m_write_request), .m_write_response(m_write_response)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int tx_occ = 0;
  int mw_count = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_cs[$];
  logic [7:0] exp_rx[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got none expected event", nm);
  endtask

  // Loopback SPI controller: busy for a few cycles after WDATA, RDATA echoes the byte.
  int         busy_cnt = 0;
  logic [7:0] rx_reg = '0;
  always @(posedge clock) begin
    if (reset) begin
      m_write_response <= 1'b0;
      m_read_response  <= 1'b0;
      m_read_data      <= '0;
      busy_cnt         <= 0;
    end else begin
      m_write_response <= m_write_request;
      m_read_response  <= m_read_request;
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (m_write_request) begin
        chk("m_write_strobe", {28'h0, m_write_strobe}, 32'hF);
        if (m_rw_address == 5'h08) begin
          if (exp_cs.size() == 0) fail_now("unexpected_cs_write");
          else chk("master_cs_write", {24'h0, m_write_data}, {24'h0, exp_cs.pop_front()});
        end else if (m_rw_address == 5'h10) begin
          if (exp_tx.size() == 0) fail_now("unexpected_tx_write");
          else chk("master_tx_write", {24'h0, m_write_data}, {24'h0, exp_tx.pop_front()});
          exp_rx.push_back(m_write_data);
          rx_reg   <= m_write_data;
          busy_cnt <= 6;
          tx_occ--;
          mw_count++;
        end else begin
          chk("master_write_addr", {27'h0, m_rw_address}, 32'h10);
        end
      end
      if (m_read_request) begin
        case (m_rw_address)
          5'h18:   m_read_data <= {31'h0, busy_cnt != 0};
          5'h14:   m_read_data <= {24'h0, rx_reg};
          default: m_read_data <= 32'h0;
        endcase
      end
    end
  end

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock);
    rw_address = a; write_data = d; write_strobe = s; write_request = 1'b1;
    if (s == 4'hF && a == 5'h00 && tx_occ < c_DEPTH) begin
      exp_tx.push_back(d[7:0]);
      tx_occ++;
    end
    if (s == 4'hF && a == 5'h0C) exp_cs.push_back(d[15:8]);
    @(negedge clock);
    write_request = 1'b0;
    chk("write_response", {31'h0, write_response}, 32'd1);
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clock);
    rw_address = a; read_request = 1'b1;
    @(negedge clock);
    read_request = 1'b0;
    d = read_data;
    chk("read_response", {31'h0, read_response}, 32'd1);
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cpu_read(5'h08, s);
      if (!s[4]) done = 1;
    end
    if (!done) fail_now("idle_timeout");
  endtask

  task automatic rx_pop_check(input string nm);
    logic [31:0] d;
    cpu_read(5'h04, d);
    if (exp_rx.size() == 0) fail_now("rx_scoreboard_empty");
    else chk(nm, d, {24'h0, exp_rx.pop_front()});
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, logic [4:0] a, logic [31:0] d, logic [3:0] s, logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    bit found;

    // Register-level vectors with enable still off.
    vecs.push_back(mk(0, 5'h08, 0, 4'h0, 32'h0000_0006));
    vecs.push_back(mk(0, 5'h0C, 0, 4'h0, 32'h0000_0000));
    vecs.push_back(mk(0, 5'h04, 0, 4'h0, 32'h0000_0000));
    vecs.push_back(mk(0, 5'h08, 0, 4'h0, 32'h0000_0006));
    vecs.push_back(mk(0, 5'h1C, 0, 4'h0, 32'hdead_beef));
`ifdef SPI_SEQ_IRQ_EN
    vecs.push_back(mk(0, 5'h10, 0, 4'h0, 32'h0000_0000));
`else
    vecs.push_back(mk(0, 5'h10, 0, 4'h0, 32'hdead_beef));
`endif
    vecs.push_back(mk(1, 5'h00, 32'h99, 4'h3, 0));
    vecs.push_back(mk(0, 5'h08, 0, 4'h0, 32'h0000_0006));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(1, 5'h00, 32'h11 + i, 4'hF, 0));
    vecs.push_back(mk(0, 5'h08, 0, 4'h0, 32'h0000_0825));
    vecs.push_back(mk(1, 5'h08, 32'h1234_5678, 4'hF, 0));
    vecs.push_back(mk(0, 5'h08, 0, 4'h0, 32'h0000_0805));

    repeat (3) @(negedge clock);
    chk("rst_read_data", read_data, 32'hdead_beef);
    chk("rst_read_response", {31'h0, read_response}, 32'd0);
    chk("rst_write_response", {31'h0, write_response}, 32'd0);
    chk("rst_m_read_request", {31'h0, m_read_request}, 32'd0);
    chk("rst_m_write_request", {31'h0, m_write_request}, 32'd0);
    chk("rst_m_rw_address", {27'h0, m_rw_address}, 32'd0);
    chk("rst_m_write_data", {24'h0, m_write_data}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      else begin
        cpu_read(vecs[i].addr, rd);
        chk($sformatf("vec%0d_addr%h", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // Enable with 8 queued bytes and no RX reads: RX fills, one more byte waits.
    cpu_write(5'h0C, 32'h0000_0001, 4'hF);
    wait_idle();
    cpu_read(5'h08, rd);
    chk("fill_status", rd, 32'h0008_000A);
    chk("fill_bytes_sent", mw_count, 8);
    cpu_write(5'h00, 32'h5A, 4'hF);
    repeat (30) @(negedge clock);
    cpu_read(5'h08, rd);
    chk("blocked_status", rd, 32'h0008_0118);
    chk("blocked_bytes_sent", mw_count, 8);
    for (int i = 0; i < 8; i++) rx_pop_check($sformatf("fill_rx%0d", i));
    wait_idle();
    rx_pop_check("queued_rx");
    cpu_read(5'h08, rd);
    chk("drained_status", rd, 32'h0000_0006);

    // Loopback byte with a new chip-select value.
    cpu_write(5'h0C, 32'h0000_3C01, 4'hF);
    cpu_write(5'h00, 32'hA5, 4'hF);
    wait_idle();
    cpu_read(5'h04, rd);
    chk("loopback_rx", rd, 32'h0000_00A5);
    if (exp_rx.size() != 0) void'(exp_rx.pop_front());
    cpu_read(5'h08, rd);
    chk("loopback_status", rd, 32'h0000_0006);
    cpu_read(5'h0C, rd);
    chk("control_readback", rd, 32'h0000_3C01);

`ifdef SPI_SEQ_IRQ_EN
    cpu_write(5'h10, 32'h1, 4'hF);
    cpu_write(5'h00, 32'h31, 4'hF);
    cpu_write(5'h00, 32'h32, 4'hF);
    chk("irq_low_while_busy", {31'h0, irq}, 32'd0);
    wait_idle();
    repeat (2) @(negedge clock);
    chk("irq_after_done", {31'h0, irq}, 32'd1);
    rx_pop_check("irq_rx0");
    rx_pop_check("irq_rx1");
    cpu_write(5'h10, 32'h0, 4'hF);
`endif

    // Reset while the sequencer is polling the controller.
    cpu_write(5'h00, 32'h77, 4'hF);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (m_read_request && m_rw_address == 5'h18) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now("poll_not_reached");
    reset = 1'b1;
    @(negedge clock);
    chk("reset_m_read_request", {31'h0, m_read_request}, 32'd0);
    chk("reset_m_rw_address", {27'h0, m_rw_address}, 32'd0);
    reset = 1'b0;
    exp_tx.delete(); exp_cs.delete(); exp_rx.delete(); tx_occ = 0;
    cpu_read(5'h08, rd);
    chk("reset_status", rd, 32'h0000_0006);
    cpu_read(5'h0C, rd);
    chk("reset_control", rd, 32'h0000_0000);
    cpu_read(5'h04, rd);
    chk("reset_rx_empty", rd, 32'h0000_0000);
    repeat (20) @(negedge clock);
    chk("no_writes_after_reset", exp_cs.size() + exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
